// File: rtl/latch_wr_arbiter.sv
// Round-robin arbiter that serialises requester writes into a shared latch bank.
// Each write is sequenced as setup, enable pulse, hold and an optional idle gap.
module latch_wr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [DW-1:0]       lat_d,
  output logic                lat_c,
  output logic                busy
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [N_REQ-1:0]  gnt_nxt, done_nxt;
  logic [DW-1:0]     lat_d_nxt;
  logic              lat_c_nxt, busy_nxt;

  logic              found;
  logic [IW-1:0]     win;

  // Walk downward so the candidate nearest to ptr+1 is the last one written.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    lat_d_nxt = lat_d;
    lat_c_nxt = 1'b0;
    busy_nxt  = busy;

    unique case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt = S_SETUP;
          ptr_nxt   = win;
          gnt_nxt   = N_REQ'(1) << win;
          lat_d_nxt = wdata[win*DW +: DW];
          busy_nxt  = 1'b1;
        end
      end
      S_SETUP: begin
        state_nxt = S_PULSE;
        lat_c_nxt = 1'b1;
        cnt_nxt   = 4'(PULSE_W - 1);
      end
      S_PULSE: begin
        if (cnt == 4'd0) begin
          state_nxt = S_HOLD;
          done_nxt  = gnt;
        end else begin
          cnt_nxt   = cnt - 4'd1;
          lat_c_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        gnt_nxt = '0;
        if (GAP_W == 0) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt = S_GAP;
          cnt_nxt   = 4'(GAP_W - 1);
        end
      end
      S_GAP: begin
        if (cnt == 4'd0) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= IW'(N_REQ - 1);
      gnt   <= '0;
      done  <= '0;
      lat_d <= '0;
      lat_c <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      lat_d <= lat_d_nxt;
      lat_c <= lat_c_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Directed bench for latch_wr_arbiter: default instance plus a PULSE_W=1/GAP_W=0 instance.
module tb_latch_wr_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req,    gnt,    done;
  logic [31:0] wdata;
  logic [7:0]  lat_d;
  logic        lat_c,  busy;

  logic [3:0]  req_b,  gnt_b,  done_b;
  logic [31:0] wdata_b;
  logic [7:0]  lat_d_b;
  logic        lat_c_b, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  latch_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt),
    .done(done), .lat_d(lat_d), .lat_c(lat_c), .busy(busy)
  );

  latch_wr_arbiter #(.N_REQ(4), .DW(8), .PULSE_W(1), .GAP_W(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .wdata(wdata_b), .gnt(gnt_b),
    .done(done_b), .lat_d(lat_d_b), .lat_c(lat_c_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    wdata   = '0;
    req_b   = '0;
    wdata_b = '0;

    // Reset state
    step();
    step();
    check("rst_gnt",   gnt,   4'b0000);
    check("rst_lat_c", lat_c, 1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_lat_d", lat_d, 8'h00);
    check("rst_done",  done,  4'b0000);
    rst_n = 1'b1;

    // Single request, requester 0
    req   = 4'b0001;
    wdata = 32'h0000_00A5;
    step();
    check("single_gnt",   gnt,   4'b0001);
    check("single_lat_d", lat_d, 8'hA5);
    check("single_setup", lat_c, 1'b0);
    check("single_busy",  busy,  1'b1);
    req = '0;
    step();
    check("single_pulse1", lat_c, 1'b1);
    step();
    check("single_pulse2", lat_c, 1'b1);
    step();
    check("single_hold_c", lat_c, 1'b0);
    check("single_done",   done,  4'b0001);
    check("single_hold_g", gnt,   4'b0001);
    step();
    check("single_gap_g",  gnt,   4'b0000);
    check("single_gap_d",  done,  4'b0000);
    check("single_gap_b",  busy,  1'b1);
    step();
    check("single_idle_b", busy,  1'b0);

    // Contention: all requesters held from reset, order 0,1,2,3,0
    rst_n = 1'b0;
    req   = 4'b1111;
    wdata = 32'h4433_2211;
    step();
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      logic [3:0] eg;
      logic [7:0] ed;
      eg = 4'b0001 << (t % 4);
      ed = 8'h11 * 8'((t % 4) + 1);
      step();
      check("cont_gnt",   gnt,   32'(eg));
      check("cont_lat_d", lat_d, 32'(ed));
      check("cont_setup", lat_c, 1'b0);
      step();
      check("cont_pulse1", lat_c, 1'b1);
      step();
      check("cont_pulse2", lat_c, 1'b1);
      step();
      check("cont_done",  done,  32'(eg));
      check("cont_hold_c", lat_c, 1'b0);
      step();
      check("cont_gap_c", lat_c, 1'b0);
      check("cont_gap_g", gnt,   4'b0000);
      step();
      check("cont_idle_c", lat_c, 1'b0);
      check("cont_idle_b", busy,  1'b0);
    end
    req = '0;

    // Data stability: requester 2 (pointer at 0 after the last grant)
    req   = 4'b0100;
    wdata = 32'h003C_0000;
    step();
    check("stab_gnt",   gnt,   4'b0100);
    check("stab_lat_d", lat_d, 8'h3C);
    wdata = 32'h00FF_0000;
    req   = '0;
    step();
    check("stab_pulse_d", lat_d, 8'h3C);
    step();
    step();
    check("stab_hold_d", lat_d, 8'h3C);
    check("stab_done",   done,  4'b0100);
    step();
    step();
    check("stab_idle_b", busy, 1'b0);

    // Early drop of req[1] during PULSE
    req   = 4'b0010;
    wdata = 32'h0000_5A00;
    step();
    check("drop_gnt", gnt, 4'b0010);
    step();
    check("drop_pulse", lat_c, 1'b1);
    req = '0;
    step();
    step();
    check("drop_done", done, 4'b0010);
    step();
    step();
    check("drop_idle_b", busy, 1'b0);
    step();
    check("drop_no_regnt", gnt,  4'b0000);
    check("drop_no_busy",  busy, 1'b0);

    // Reset mid-pulse: outputs must drop before any clock edge
    req   = 4'b0001;
    wdata = 32'h0000_0077;
    step();
    check("rpul_gnt", gnt, 4'b0001);
    req = '0;
    step();
    check("rpul_pulse", lat_c, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rpul_lat_c", lat_c, 1'b0);
    check("rpul_gnt0",  gnt,   4'b0000);
    check("rpul_busy",  busy,  1'b0);
    check("rpul_done",  done,  4'b0000);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rpul_done_after", done, 4'b0000);
    check("rpul_busy_after", busy, 1'b0);

    // PULSE_W=1, GAP_W=0: back-to-back 4-cycle transactions
    req_b   = 4'b0001;
    wdata_b = 32'h0000_00C3;
    for (int t = 0; t < 2; t++) begin
      step();
      check("b2b_gnt",   gnt_b,   4'b0001);
      check("b2b_setup", lat_c_b, 1'b0);
      check("b2b_lat_d", lat_d_b, 8'hC3);
      step();
      check("b2b_pulse", lat_c_b, 1'b1);
      step();
      check("b2b_hold_c", lat_c_b, 1'b0);
      check("b2b_done",   done_b,  4'b0001);
      step();
      check("b2b_idle_c", lat_c_b, 1'b0);
      check("b2b_idle_b", busy_b,  1'b0);
      check("b2b_idle_g", gnt_b,   4'b0000);
    end
    req_b = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
